// File: rtl/fp_mult_ctrl_pkg.sv
// Shared definitions for the GP02 8-bit floating-point multiplier controller:
// default format widths, FSM state encoding and operand field positions.
package fp_mult_ctrl_pkg;

    // Default format: [7] sign, [6:3] exponent (bias 7), [2:0] mantissa
    localparam int FP_EXP_W  = 4;
    localparam int FP_MANT_W = 3;
    localparam int FP_BIAS   = (1 << (FP_EXP_W - 1)) - 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MULT = 3'd1,
        ST_NORM = 3'd2,
        ST_EXP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Field positions inside an operand word of width 1+ew+mw
    function automatic int sign_pos(input int ew, input int mw);
        return ew + mw;
    endfunction

    function automatic int exp_msb(input int ew, input int mw);
        return ew + mw - 1;
    endfunction

    function automatic int exp_lsb(input int mw);
        return mw;
    endfunction

    function automatic int mant_msb(input int mw);
        return mw - 1;
    endfunction

endpackage

// File: rtl/mult_mantisa_seq.sv
// Sequential shift-add multiplier for the hidden-bit mantissas.
// start_i loads the operands and clears accumulator/counter; every cycle with
// en_i high performs one iteration. done_o flags the cycle whose closing edge
// completes the last iteration, so prod_o is final from the next cycle on.
module mult_mantisa_seq
    import fp_mult_ctrl_pkg::*;
#(
    parameter int N = FP_MANT_W + 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic           en_i,
    input  logic [N-1:0]   mcand_i,
    input  logic [N-1:0]   mplier_i,
    output logic [2*N-1:0] prod_o,
    output logic           done_o
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [2*N-1:0] mcand_q, mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    // Next-state: load on start, otherwise add the shifted multiplicand when
    // the current multiplier LSB is set and advance one bit position
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (start_i) begin
            mcand_d  = {{N{1'b0}}, mcand_i};
            mplier_d = mplier_i;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (en_i) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
        end
    end

    // Iteration state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign prod_o = acc_q;
    assign done_o = en_i && (cnt_q == CW'(N - 1));

endmodule

// File: rtl/fp_mult_ctrl.sv
// Sequential controller for the GP02 8-bit floating-point multiplier.
// One operand pair is taken over valid/ready, multiplied over a fixed
// MULT(4) -> NORM -> EXP sequence and held in DONE until the sink takes it.
module fp_mult_ctrl
    import fp_mult_ctrl_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int MANT_W = FP_MANT_W,
    parameter int BIAS   = FP_BIAS
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [EXP_W+MANT_W:0]   i_op_a,
    input  logic [EXP_W+MANT_W:0]   i_op_b,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [EXP_W+MANT_W:0]   o_result,
    output logic                    o_overflow,
    output logic                    o_underflow
);

    localparam int OPW  = 1 + EXP_W + MANT_W;
    localparam int SGN  = sign_pos(EXP_W, MANT_W);
    localparam int EMSB = exp_msb(EXP_W, MANT_W);
    localparam int ELSB = exp_lsb(MANT_W);
    localparam int MMSB = mant_msb(MANT_W);
    localparam int MW   = MANT_W + 1;
    localparam int PW   = 2 * MW;

    localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W + 2)'(BIAS);
    localparam logic signed [EXP_W+1:0] MAXE_S = (EXP_W + 2)'((1 << EXP_W) - 1);

    // Biased exponent sum, wide enough to see both underflow and overflow
    function automatic logic signed [EXP_W+1:0] exp_raw(
        input logic [EXP_W-1:0] ea,
        input logic [EXP_W-1:0] eb,
        input logic             c
    );
        return $signed({2'b00, ea}) + $signed({2'b00, eb})
             + $signed({{(EXP_W + 1){1'b0}}, c}) - BIAS_S;
    endfunction

    // Final packing with flush-to-zero and saturation; returns {result, ovf, unf}
    function automatic logic [OPW+1:0] pack_result(
        input logic                    sign,
        input logic                    zero,
        input logic signed [EXP_W+1:0] raw,
        input logic [MANT_W-1:0]       mant
    );
        logic [OPW+1:0] r;
        if (zero) begin
            r = {sign, {(OPW - 1){1'b0}}, 2'b00};
        end else if (raw <= 0) begin
            // exponent 0 is reserved for zero, so anything at or below it flushes
            r = {sign, {(OPW - 1){1'b0}}, 2'b01};
        end else if (raw > MAXE_S) begin
            r = {sign, {(OPW - 1){1'b1}}, 2'b10};
        end else begin
            r = {sign, raw[EXP_W-1:0], mant, 2'b00};
        end
        return r;
    endfunction

    function automatic logic is_zero(input logic [OPW-1:0] op);
        return (op[EMSB:ELSB] == '0) && (op[MMSB:0] == '0);
    endfunction

    state_t                  state_q, state_d;
    logic                    accept;
    logic                    sign_q, zero_q;
    logic [EXP_W-1:0]        exp_a_q, exp_b_q;
    logic                    carry_q;
    logic [MANT_W-1:0]       mant_q;
    logic [PW-1:0]           prod;
    logic                    mult_done;
    logic signed [EXP_W+1:0] raw;
    logic [OPW+1:0]          res_d;
    logic [OPW-1:0]          result_q;
    logic                    ovf_q, unf_q;
    logic                    unused_prod_lsbs;

    assign accept = i_valid && (state_q == ST_IDLE);

    mult_mantisa_seq #(
        .N (MW)
    ) u_mult (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .start_i  (accept),
        .en_i     (state_q == ST_MULT),
        .mcand_i  ({1'b1, i_op_a[MMSB:0]}),
        .mplier_i ({1'b1, i_op_b[MMSB:0]}),
        .prod_o   (prod),
        .done_o   (mult_done)
    );

    // Truncated-away product bits below the normalised mantissa
    assign unused_prod_lsbs = &{1'b0, prod[PW-MANT_W-3:0]};

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: fixed sequence, only IDLE and DONE wait on handshakes
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_valid) state_d = ST_MULT;
            ST_MULT: if (mult_done) state_d = ST_NORM;
            ST_NORM: state_d = ST_EXP;
            ST_EXP:  state_d = ST_DONE;
            ST_DONE: if (i_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture on accept and carry/mantissa extraction in NORM
    always_ff @(posedge i_clk) begin
        if (accept) begin
            sign_q  <= i_op_a[SGN] ^ i_op_b[SGN];
            zero_q  <= is_zero(i_op_a) || is_zero(i_op_b);
            exp_a_q <= i_op_a[EMSB:ELSB];
            exp_b_q <= i_op_b[EMSB:ELSB];
        end
        if (state_q == ST_NORM) begin
            carry_q <= prod[PW-1];
            mant_q  <= prod[PW-1] ? prod[PW-2 -: MANT_W] : prod[PW-3 -: MANT_W];
        end
    end

    assign raw   = exp_raw(exp_a_q, exp_b_q, carry_q);
    assign res_d = pack_result(sign_q, zero_q, raw, mant_q);

    // Result and flags, loaded in EXP and held through DONE until the next EXP
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else if (state_q == ST_EXP) begin
            {result_q, ovf_q, unf_q} <= res_d;
        end
    end

    assign o_ready     = (state_q == ST_IDLE);
    assign o_valid     = (state_q == ST_DONE);
    assign o_result    = result_q;
    assign o_overflow  = ovf_q;
    assign o_underflow = unf_q;

endmodule

// File: tb/tb_fp_mult_ctrl.sv
// Scoreboard bench for fp_mult_ctrl: the driver queues expected results at
// acceptance, the monitor pops and checks on each rising o_valid.
module tb_fp_mult_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_valid, i_ready;
    logic       o_ready, o_valid, o_overflow, o_underflow;
    logic [7:0] op_a, op_b, o_result;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fp_mult_ctrl dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_op_a      (op_a),
        .i_op_b      (op_b),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow)
    );

    typedef struct {
        logic [7:0] r;
        logic       ovf;
        logic       unf;
        int         acc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   seen  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired (t=%0t)", nm, $time);
    endtask

    // Monitor: check each new result against the oldest queued expectation
    always @(negedge clk) begin
        if (o_valid && !seen) begin
            if (q.size() == 0) begin
                fail_now("unexpected_valid");
            end else begin
                mon_e = q.pop_front();
                chk("result", {24'd0, o_result}, {24'd0, mon_e.r});
                chk("overflow", {31'd0, o_overflow}, {31'd0, mon_e.ovf});
                chk("underflow", {31'd0, o_underflow}, {31'd0, mon_e.unf});
                chk("latency", cyc - mon_e.acc, 32'd6);
            end
        end
        seen = o_valid;
    end

    task automatic wait_ready(input string nm, output bit ok);
        int n = 0;
        @(negedge clk);
        while (!o_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = o_ready;
        if (!ok) fail_now(nm);
    endtask

    task automatic run_op(input logic [7:0] xa, input logic [7:0] xb,
                          input logic [7:0] er, input logic eo, input logic eu);
        bit ok;
        exp_t e;
        wait_ready("accept_timeout", ok);
        if (ok) begin
            op_a    = xa;
            op_b    = xb;
            i_valid = 1'b1;
            @(posedge clk);
            #1;
            e.r   = er;
            e.ovf = eo;
            e.unf = eu;
            e.acc = cyc;
            q.push_back(e);
            i_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            fail_now("drain_timeout");
            q.delete();
        end
    endtask

    initial begin
        int  n;
        bit  ok;
        rst     = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        op_a    = 8'h00;
        op_b    = 8'h00;
        repeat (2) @(negedge clk);

        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_result", {24'd0, o_result}, 32'd0);
        chk("rst_ovf", {31'd0, o_overflow}, 32'd0);
        chk("rst_unf", {31'd0, o_underflow}, 32'd0);
        rst = 1'b0;

        run_op(8'h38, 8'h38, 8'h38, 1'b0, 1'b0);
        run_op(8'h3C, 8'h3C, 8'h41, 1'b0, 1'b0);
        run_op(8'h78, 8'h78, 8'h7F, 1'b1, 1'b0);
        run_op(8'h08, 8'h08, 8'h00, 1'b0, 1'b1);
        run_op(8'h80, 8'h45, 8'h80, 1'b0, 1'b0);
        drain();

        // Consumer stall in DONE with competing operands offered
        i_ready = 1'b0;
        run_op(8'hBC, 8'h3C, 8'hC1, 1'b0, 1'b0);
        n = 0;
        while (!o_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stall_reach", {31'd0, o_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'd0, o_valid}, 32'd1);
            chk("stall_result", {24'd0, o_result}, 32'hC1);
            chk("stall_ready", {31'd0, o_ready}, 32'd0);
            op_a    = 8'h78;
            op_b    = 8'h78;
            i_valid = 1'b1;
            @(negedge clk);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        chk("release_valid", {31'd0, o_valid}, 32'd0);
        chk("release_ready", {31'd0, o_ready}, 32'd1);
        run_op(8'h3C, 8'h3C, 8'h41, 1'b0, 1'b0);
        run_op(8'h78, 8'h78, 8'h7F, 1'b1, 1'b0);
        drain();

        // Reset while the multiplier is iterating
        wait_ready("mid_accept_timeout", ok);
        if (ok) begin
            op_a    = 8'h3C;
            op_b    = 8'h3C;
            i_valid = 1'b1;
            @(posedge clk);
            #1;
            i_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            chk("mid_ready", {31'd0, o_ready}, 32'd0);
            rst = 1'b1;
            #1;
            chk("mid_rst_ready", {31'd0, o_ready}, 32'd1);
            chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
            chk("mid_rst_result", {24'd0, o_result}, 32'd0);
            chk("mid_rst_ovf", {31'd0, o_overflow}, 32'd0);
            chk("mid_rst_unf", {31'd0, o_underflow}, 32'd0);
            @(negedge clk);
            rst = 1'b0;
        end
        run_op(8'h38, 8'h38, 8'h38, 1'b0, 1'b0);
        drain();

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fp_mult_ctrl.md
Name: fp_mult_ctrl

Overview:
- Sequential controller for the GP02 8-bit floating-point multiplier. Format: [7] sign, [6:3] exponent (bias 7), [2:0] mantissa with hidden leading 1.
- Accepts one operand pair over a valid/ready handshake.
- Sequences the datapath in order:
  - shift-add mantissa multiply, 4 iterations
  - normalization (carry extraction)
  - biased exponent add with overflow/underflow handling
- Holds the result until the consumer takes it. Sits between the operand source and the result sink at the top level.

Parameters:
- EXP_W, 4, exponent field width.
- MANT_W, 3, stored mantissa width (hidden bit excluded).
- BIAS, 7, exponent bias, equal to 2^(EXP_W-1)-1.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_valid  input  1  operand pair valid.
- o_ready  output  1  controller can accept operands; high only in IDLE.
- i_op_a  input  1+EXP_W+MANT_W  operand A.
- i_op_b  input  1+EXP_W+MANT_W  operand B.
- o_valid  output  1  result valid; high only in DONE.
- i_ready  input  1  consumer accepts result.
- o_result  output  1+EXP_W+MANT_W  product.
- o_overflow  output  1  result saturated; qualified by o_valid.
- o_underflow  output  1  result flushed to zero; qualified by o_valid.

Behaviour:
- Clock and reset: one clock (i_clk); reset i_rst is asynchronous and active-high.
- Reset values: state=IDLE, o_ready=1, o_valid=0, o_result=0, o_overflow=0, o_underflow=0, iteration counter=0.
- State sequence: IDLE -> MULT -> NORM -> EXP -> DONE -> IDLE.
- IDLE:
  - On edge with i_valid&o_ready: register operands, sign = a[7]^b[7], zero flag (either operand has exponent==0 and mantissa==0).
  - Clear accumulator and counter, go to MULT.
- MULT:
  - One shift-add iteration per cycle on {1,mant_a} x {1,mant_b}; 2*(MANT_W+1)=8-bit product.
  - Counter 0..3; after the 4th iteration go to NORM.
- NORM:
  - carry = prod[7].
  - Mantissa = carry ? prod[6:4] : prod[5:3] (truncation, no rounding).
  - Go to EXP.
- EXP: raw = exp_a + exp_b + carry - BIAS, computed signed, EXP_W+2 = 6 bits wide.
  - zero flag set: result = {sign, 0...0}; no flags.
  - raw <= 0: result = {sign, 0...0}, o_underflow=1. Exponent 0 is reserved for zero.
  - raw > 2^EXP_W-1 (15): result = {sign, all-ones exponent, all-ones mantissa}, o_overflow=1.
  - Otherwise: result = {sign, raw[3:0], mantissa}.
  - Register o_result and flags, set o_valid, go to DONE.
- DONE:
  - o_result and flags stable while o_valid && !i_ready.
  - On edge with i_ready: o_valid=0, go to IDLE (o_ready=1 the next cycle).
  - Flags keep their value until the next EXP.
- Latency: acceptance edge N -> o_valid high after edge N+6. Fixed, including zero operands.
- Throughput: at most one operation every 8 cycles when i_ready is held high. No overlap; o_ready=0 from MULT through DONE.
- Handshake rules:
  - i_valid while o_ready=0 is ignored; the operands are not captured.
  - i_ready outside DONE is ignored.
- Reset mid-operation: any state returns to IDLE immediately; an in-flight result is discarded and o_valid drops asynchronously.
- Denormals, NaN and infinity are not supported. All-ones exponent is an ordinary value.

Decomposition:
- Shared package / include file holds:
  - EXP_W, MANT_W, BIAS
  - state encoding (IDLE, MULT, NORM, EXP, DONE; 3 bits)
  - field slice positions for sign, exponent and mantissa
- One natural sub-module, mult_mantisa_seq: 4-bit x 4-bit shift-add multiplier.
  - Inputs: start, multiplicand, multiplier.
  - Outputs: 8-bit product and done.
  - Driven by the MULT state.
- Normalization, exponent arithmetic and the FSM stay in fp_mult_ctrl.

Test Plan:
- 0x38 x 0x38 (1.0x1.0), i_ready=1 -> o_valid exactly 6 cycles after accept, o_result=0x38, no flags.
- 0x3C x 0x3C (1.5x1.5) -> carry=1, o_result=0x41 (exp 8, mant 001); 0xBC x 0x3C -> 0xC1.
- 0x78 x 0x78 -> raw 23 -> o_result=0x7F, o_overflow=1; 0x08 x 0x08 -> raw -5 -> o_result=0x00, o_underflow=1.
- 0x80 x 0x45 (negative zero operand) -> o_result=0x80, no flags, latency still 6.
- i_ready low 5 cycles in DONE -> o_result/o_valid stable, o_ready=0, new i_valid ignored; i_ready high -> IDLE, next pair accepted.
- Assert i_rst during MULT (cycle N+2) -> outputs at reset values immediately; following 0x38 x 0x38 completes normally with 0x38.
